// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache controller.
package dcache_miss_ctrl_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 32;
  localparam int INDEX_W_DEF  = 6;
  localparam int OFFSET_W_DEF = 2;

  localparam int TAG_W_DEF      = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF - 2;
  localparam int LINE_WORDS_DEF = 1 << OFFSET_W_DEF;

  // Encoding of mem_we on the DRAM request channel.
  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_FILL = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_DONE = 3'd5
  } state_e;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w - 2;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: one lookup port, one tag probe,
// one word-write port and one tag/valid-set port.
module dcache_line_store
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_idx,
  input  logic [OFFSET_W-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [INDEX_W-1:0]  probe_idx,
  output logic                probe_valid,
  output logic [TAG_W-1:0]    probe_tag,
  input  logic                word_we,
  input  logic [INDEX_W-1:0]  word_idx,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [DATA_W-1:0]   word_data,
  input  logic                fill_set,
  input  logic [INDEX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]    fill_tag
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_set) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (fill_set) begin
      tag_mem[fill_idx] <= fill_tag;
    end
    if (word_we) begin
      data_mem[{word_idx, word_off}] <= word_data;
    end
  end

  assign rd_valid    = valid_q[rd_idx];
  assign rd_tag      = tag_mem[rd_idx];
  assign rd_data     = data_mem[{rd_idx, rd_off}];
  assign probe_valid = valid_q[probe_idx];
  assign probe_tag   = tag_mem[probe_idx];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped, write-through, no-write-allocate D-cache miss controller.
// Optional hit/miss/write counters are enabled with the DCACHE_STATS_EN macro.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dram_cache_miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes
`endif
);

  localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WADR_W = ADDR_W - 2;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

  state_e state_q, state_d;

  logic [WADR_W-1:0]   lat_word_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [OFFSET_W-1:0] beat_q;

  logic [WADR_W-1:0]   cpu_word;
  logic [OFFSET_W-1:0] cpu_off, lat_off;
  logic [INDEX_W-1:0]  cpu_idx, lat_idx;
  logic [TAG_W-1:0]    cpu_tag, lat_tag;
  logic [1:0]          unused_byte_bits;

  logic                rd_valid, probe_valid;
  logic [TAG_W-1:0]    rd_tag, probe_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                hit, lat_line_hit;

  logic                latch_wr, latch_rd, beat_inc;
  logic                word_we, fill_set;
  logic [OFFSET_W-1:0] word_off;
  logic [DATA_W-1:0]   word_data;

  assign cpu_word         = cpu_addr[ADDR_W-1:2];
  assign unused_byte_bits = cpu_addr[1:0];
  assign cpu_off = cpu_word[OFFSET_W-1:0];
  assign cpu_idx = cpu_word[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign cpu_tag = cpu_word[WADR_W-1:INDEX_W+OFFSET_W];
  assign lat_off = lat_word_q[OFFSET_W-1:0];
  assign lat_idx = lat_word_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign lat_tag = lat_word_q[WADR_W-1:INDEX_W+OFFSET_W];

  dcache_line_store #(
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .TAG_W   (TAG_W)
  ) u_line_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (cpu_idx),
    .rd_off     (cpu_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .probe_idx  (lat_idx),
    .probe_valid(probe_valid),
    .probe_tag  (probe_tag),
    .word_we    (word_we && !rst),
    .word_idx   (lat_idx),
    .word_off   (word_off),
    .word_data  (word_data),
    .fill_set   (fill_set && !rst),
    .fill_idx   (lat_idx),
    .fill_tag   (lat_tag)
  );

  assign hit          = rd_valid && (rd_tag == cpu_tag);
  assign lat_line_hit = probe_valid && (probe_tag == lat_tag);
  assign cpu_rdata    = cpu_re ? rd_data : '0;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d         = state_q;
    dram_cache_miss = 1'b0;
    mem_req         = 1'b0;
    mem_we          = MEM_OP_READ;
    mem_addr        = '0;
    mem_wdata       = '0;
    latch_wr        = 1'b0;
    latch_rd        = 1'b0;
    beat_inc        = 1'b0;
    word_we         = 1'b0;
    word_off        = beat_q;
    word_data       = mem_rdata;
    fill_set        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stores take priority; a simultaneous load is retried once the store retires.
        if (cpu_we) begin
          dram_cache_miss = 1'b1;
          latch_wr        = 1'b1;
          state_d         = ST_WR_REQ;
        end else if (cpu_re && !hit) begin
          dram_cache_miss = 1'b1;
          latch_rd        = 1'b1;
          state_d         = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        dram_cache_miss = 1'b1;
        mem_req         = 1'b1;
        mem_addr        = {lat_word_q[WADR_W-1:OFFSET_W], {(OFFSET_W + 2){1'b0}}};
        if (mem_gnt) state_d = ST_RD_FILL;
      end
      ST_RD_FILL: begin
        dram_cache_miss = 1'b1;
        if (mem_rvalid) begin
          word_we  = 1'b1;
          beat_inc = 1'b1;
          if (beat_q == LAST_BEAT) begin
            fill_set = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_WR_REQ: begin
        dram_cache_miss = 1'b1;
        mem_req         = 1'b1;
        mem_we          = MEM_OP_WRITE;
        mem_addr        = {lat_word_q, 2'b00};
        mem_wdata       = lat_wdata_q;
        if (mem_gnt) begin
          if (mem_wack) begin
            word_we   = lat_line_hit;
            word_off  = lat_off;
            word_data = lat_wdata_q;
            state_d   = ST_WR_DONE;
          end else begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_WR_WAIT: begin
        dram_cache_miss = 1'b1;
        if (mem_wack) begin
          word_we   = lat_line_hit;
          word_off  = lat_off;
          word_data = lat_wdata_q;
          state_d   = ST_WR_DONE;
        end
      end
      ST_WR_DONE: begin
        // One unstalled cycle lets the pipeline move past the held store.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_word_q  <= '0;
      lat_wdata_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q <= state_d;
      if (latch_wr || latch_rd) lat_word_q <= cpu_word;
      if (latch_wr) lat_wdata_q <= cpu_wdata;
      if (latch_rd) begin
        beat_q <= '0;
      end else if (beat_inc) begin
        beat_q <= beat_q + OFFSET_W'(1);
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_writes <= '0;
    end else begin
      if (state_q == ST_IDLE && cpu_re && !cpu_we && hit) stat_hits <= sat_inc(stat_hits);
      if (latch_rd) stat_misses <= sat_inc(stat_misses);
      if (state_q == ST_WR_DONE) stat_writes <= sat_inc(stat_writes);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: a behavioural cache/DRAM model predicts load data
// and memory requests; a monitor compares them whenever the DUT presents them.
module tb_dcache_miss_ctrl;

  localparam int LINES = 64;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dram_cache_miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid, mem_wack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .dram_cache_miss(dram_cache_miss),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_wack       (mem_wack)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  int          total = 0;
  int          bad   = 0;
  bit          hung  = 0;
  bit          abort = 0;
  int          beats_sent = 0;
  req_t        req_q[$];
  logic [31:0] rd_q[$];

  // Reference model: external memory contents plus the lines the cache should hold.
  logic [31:0] dram [int unsigned];
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned k = a / 4;
    if (dram.exists(k)) return dram[k];
    return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DRAM controller responder: random grant delay, beat gaps and write-ack timing.
  task automatic serve();
    bit          is_wr;
    logic [31:0] a;
    is_wr = mem_we;
    a     = mem_addr;
    repeat ($urandom_range(0, 2)) tick();
    mem_gnt = 1'b1;
    if (is_wr) begin
      if ($urandom_range(0, 1) == 1) begin
        mem_wack = 1'b1;
        tick();
        mem_gnt  = 1'b0;
        mem_wack = 1'b0;
      end else begin
        tick();
        mem_gnt = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
      end
    end else begin
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        if (abort) break;
        repeat ($urandom_range(0, 1)) tick();
        if (abort) break;
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(a + 32'(4 * i));
        tick();
        mem_rvalid = 1'b0;
        beats_sent++;
      end
    end
  endtask

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    mem_rdata  = '0;
    forever begin
      tick();
      if (mem_req === 1'b1 && !rst && !abort) serve();
    end
  end

  // Monitor: a load completes on any unstalled cycle with cpu_re alone; a request on its grant.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_re && !cpu_we && dram_cache_miss === 1'b0) begin
          if (rd_q.size() == 0) check("unexpected_load", cpu_rdata, 32'hxxxx_xxxx);
          else check("load_data", cpu_rdata, rd_q.pop_front());
        end
        if (mem_req === 1'b1 && mem_gnt) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", mem_addr, 32'hxxxx_xxxx);
          end else begin
            e = req_q.pop_front();
            check("req_we", 32'(mem_we), 32'(e.we));
            check("req_addr", mem_addr, e.addr);
            if (e.we) check("req_wdata", mem_wdata, e.data);
          end
        end
      end
    end
  end

  task automatic wait_release(input string nm);
    int n = 0;
    while (dram_cache_miss !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (dram_cache_miss !== 1'b0) begin
      check(nm, 32'(dram_cache_miss), 32'd0);
      hung = 1;
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 16) % LINES);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data);
    int i = idx_of(addr);
    dram[addr / 4] = data;
    if (m_valid[i] && m_tag[i] == addr / 1024) m_data[i][(addr / 4) % WORDS] = data;
    req_q.push_back('{1'b1, addr & ~32'h3, data});
  endtask

  task automatic issue_load(input logic [31:0] addr);
    int i;
    bit hit;
    logic [31:0] line;
    if (hung) return;
    i    = idx_of(addr);
    line = addr & ~32'hF;
    hit  = m_valid[i] && (m_tag[i] == addr / 1024);
    if (!hit) begin
      req_q.push_back('{1'b0, line, 32'h0});
      m_valid[i] = 1;
      m_tag[i]   = addr / 1024;
      for (int w = 0; w < WORDS; w++) m_data[i][w] = mem_word(line + 32'(4 * w));
    end
    rd_q.push_back(m_data[i][(addr / 4) % WORDS]);
    cpu_re   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    @(negedge clk);
    check("load_first_stall", 32'(dram_cache_miss), 32'(!hit));
    wait_release("load_release_timeout");
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic issue_store(input logic [31:0] addr, input logic [31:0] data, input bit with_load);
    if (hung) return;
    model_store(addr, data);
    cpu_re    = with_load;
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    @(negedge clk);
    check("store_first_stall", 32'(dram_cache_miss), 32'd1);
    wait_release("store_release_timeout");
    tick();
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    if (with_load) issue_load(addr);
  endtask

  initial begin
    int n;
    int base;
    logic [31:0] a;
    rst = 1'b1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    for (int w = 0; w < WORDS; w++) dram[32'h10 / 4 + w] = 32'hA0 + w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(dram_cache_miss), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed sequence from the plan.
    issue_load(32'h0000_0010);
    issue_load(32'h0000_001C);
    issue_store(32'h0000_0014, 32'h55, 0);
    issue_load(32'h0000_0014);
    issue_store(32'h0000_0400, 32'hCAFE_0400, 0);
    issue_load(32'h0000_0400);

    // Reset in the middle of a refill of 0x100, after two beats.
    req_q.push_back('{1'b0, 32'h0000_0100, 32'h0});
    base     = beats_sent;
    cpu_re   = 1'b1;
    cpu_addr = 32'h0000_0100;
    n = 0;
    while (beats_sent - base < 2 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (beats_sent - base < 2) begin
      check("rst_refill_beats", 32'(beats_sent - base), 32'd2);
      hung = 1;
    end
    rst    = 1'b1;
    abort  = 1'b1;
    cpu_re = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(dram_cache_miss), 32'd0);
    @(posedge clk);
    #3;
    rst   = 1'b0;
    abort = 1'b0;
    issue_load(32'h0000_0100);

    // Load and store together: store first, load afterwards.
    issue_store(32'h0000_0020, 32'h1234_5678, 1);

    // Randomised traffic over a few lines and tags so hits, misses and conflicts all occur.
    for (int k = 0; k < 250 && !hung; k++) begin
      a = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      case ($urandom_range(0, 19))
        0, 1:             issue_store(a, $urandom, 1);
        2, 3, 4, 5, 6, 7: issue_store(a, $urandom, 0);
        default:          issue_load(a);
      endcase
      repeat ($urandom_range(0, 1)) tick();
    end

    repeat (4) tick();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller on the EX/MEM data port.
- Produces the `dram_cache_miss` stall request that the pipeline hazard unit consumes. Holds it high until the pending load or store has been serviced by external memory.
- Refills whole lines over a request/grant plus per-beat-valid burst interface to the DRAM controller.

Parameters:
- DATA_W, 32, data word width; addresses are byte addresses, word-aligned.
- ADDR_W, 32, CPU/memory address width.
- INDEX_W, 6, line-index bits (64 lines).
- OFFSET_W, 2, word-offset bits (4 words per line).
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W-2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- cpu_re  in  1  load request (held by CPU while stalled).
- cpu_we  in  1  store request (held by CPU while stalled).
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data, valid when cpu_re && !dram_cache_miss.
- dram_cache_miss  out  1  stall request to the hazard unit.
- mem_req  out  1  memory request, held until mem_gnt.
- mem_we  out  1  1 = single-word write, 0 = line burst read.
- mem_addr  out  ADDR_W  line-aligned for reads; word address for writes.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  request accepted (sampled only while mem_req=1).
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  DATA_W  read beat data.
- mem_wack  in  1  write completed.

Behaviour:
- Lookup is combinational: hit = valid[idx] && tag[idx]==addr tag; cpu_rdata = data[idx][offset] (0 when !cpu_re).
- Arrays: valid (register, cleared by rst); tag and data (no reset).
- FSM states: IDLE, RD_REQ, RD_FILL, WR_REQ, WR_WAIT, WR_DONE. Reset state IDLE.
- Output reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dram_cache_miss=0, beat counter=0.
- dram_cache_miss is combinational:
  - 1 in IDLE when (cpu_we) or (cpu_re && !hit);
  - 1 in RD_REQ, RD_FILL, WR_REQ and WR_WAIT;
  - 0 in WR_DONE.
- Request priority: cpu_we wins over cpu_re when both are asserted. The hazard unit already stalls on that crash; the load is retried afterwards.
- IDLE:
  - cpu_we: latch addr/wdata, go to WR_REQ.
  - cpu_re && miss: latch line address, clear beat counter, go to RD_REQ.
  - cpu_re && hit: zero latency, stay in IDLE.
- RD_REQ: mem_req=1, mem_we=0, mem_addr={tag,idx,OFFSET_W'0,2'b0}; on mem_gnt go to RD_FILL.
- RD_FILL:
  - Each mem_rvalid writes mem_rdata into word[beat] and increments beat.
  - Beats arrive in order, word 0 first.
  - On the last beat (beat == 2^OFFSET_W-1): write tag, set valid, go to IDLE.
  - The next cycle re-looks-up, hits, and drops the stall. Read-miss latency to release = grant wait + beats + 1.
  - mem_rvalid outside RD_FILL is ignored.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=latched word address, mem_wdata=latched data; on mem_gnt go to WR_WAIT.
- WR_WAIT:
  - On mem_wack: if the latched line is valid and the tag matches, update that cache word; then go to WR_DONE.
  - Line not present: no allocate.
- WR_DONE: one cycle with stall released so the pipeline advances past the held store; unconditionally return to IDLE. This prevents reissuing the store.
- mem_gnt and mem_wack in the same cycle in WR_REQ: the ack counts; go straight to WR_DONE.
- rst mid-operation: FSM to IDLE, all valid bits cleared, mem_req dropped the same edge. Any in-flight burst or write ack from memory is ignored.
- Partial line is never marked valid; the valid bit is set only on the final beat.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - adds outputs stat_hits, stat_misses, stat_writes (32 bits each, saturating at all-ones, cleared by rst);
  - a hit counts once per IDLE-state hit cycle;
  - a miss counts on the IDLE→RD_REQ transition;
  - a write counts on WR_DONE.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state enum, field-extract constants (TAG_W, line word count), and the mem_we encoding constants.
- One natural sub-module, dcache_line_store: the valid/tag/data arrays with a combinational read port, a word-write port, and a tag/valid-set port.

Test Plan:
- Cold load to 0x0000_0010 → stall=1 in IDLE; mem_req with mem_addr=0x0000_0010 until gnt; after 4 rvalid beats 0xA0..0xA3, stall drops the next cycle; cpu_rdata=0xA0.
- Load 0x0000_001C right after the refill → hit, no stall, cpu_rdata=0xA3, mem_req stays 0.
- Store 0x55 to 0x0000_0014 (line present) → mem_we=1, mem_addr=0x14; stall held until wack, then one WR_DONE cycle with stall=0; subsequent load of 0x14 returns 0x55 without a miss.
- Store to an uncached 0x0000_0400 → write issued; the line stays invalid and a following load of 0x400 misses.
- Refill of 0x0000_0100 with rst asserted after beat 2 → mem_req=0 next cycle; line invalid; reissuing the load re-requests 0x0000_0100.
- cpu_re and cpu_we together at 0x0000_0020 → write serviced first; the load is handled after WR_DONE.
